// File: rtl/ascon_init_ctrl.sv
`timescale 1ns/1ps
// Ascon-128 initialization controller: loads IV||K||N, steps the attached Ascon-p
// datapath for 12 rounds, applies the final key XOR and hands the state off.
//
// state | meaning
// IDLE  | waiting for start; S-box LUT writes are forwarded to the permutation
// PERM  | permutation running, UROL rounds per cycle, LUT writes dropped
// DONE  | initialized state presented on x*_o, waiting for ready_i
module ascon_init_ctrl #(
    parameter int          UROL = 1,
    parameter logic [63:0] IV   = 64'h80400c0600000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    output logic         start_ready_o,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic         sbox_wr_i,
    input  logic [4:0]   sbox_addr_i,
    input  logic [20:0]  sbox_data_i,
    output logic         sbox_ack_o,
    output logic         upd_sbox_o,
    output logic [4:0]   sbox_addr_o,
    output logic [20:0]  sbox_new_data_o,
    output logic [3:0]   round_cnt_o,
    output logic [63:0]  x0_o,
    output logic [63:0]  x1_o,
    output logic [63:0]  x2_o,
    output logic [63:0]  x3_o,
    output logic [63:0]  x4_o,
    input  logic [63:0]  x0_i,
    input  logic [63:0]  x1_i,
    input  logic [63:0]  x2_i,
    input  logic [63:0]  x3_i,
    input  logic [63:0]  x4_i,
    output logic         valid_o,
    input  logic         ready_i
);

    localparam logic [3:0] ROUNDS = 4'hC;
    localparam logic [3:0] STEP   = 4'(UROL);

    typedef enum logic [1:0] {IDLE, PERM, DONE} state_t;

    state_t       state, state_nxt;
    logic         start_acc;
    logic         wr_acc;
    logic         last_round;
    logic [127:0] key_q;

    assign last_round = (round_cnt_o == STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i && !sbox_wr_i) state_nxt = PERM;
            PERM:    if (last_round)            state_nxt = DONE;
            DONE:    if (ready_i)               state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // A pending LUT write blocks start so the S-box is settled before a run begins.
    always_comb begin
        start_ready_o = (state == IDLE) && !sbox_wr_i;
        start_acc     = start_i && start_ready_o;
        wr_acc        = (state == IDLE) && sbox_wr_i;
        valid_o       = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_o        <= '0;
            x1_o        <= '0;
            x2_o        <= '0;
            x3_o        <= '0;
            x4_o        <= '0;
            round_cnt_o <= ROUNDS;
            key_q       <= '0;
        end else if (start_acc) begin
            x0_o        <= IV;
            x1_o        <= key_i[127:64];
            x2_o        <= key_i[63:0];
            x3_o        <= nonce_i[127:64];
            x4_o        <= nonce_i[63:0];
            round_cnt_o <= ROUNDS;
            key_q       <= key_i;
        end else if (state == PERM) begin
            x0_o <= x0_i;
            x1_o <= x1_i;
            x2_o <= x2_i;
            if (last_round) begin
                x3_o        <= x3_i ^ key_q[127:64];
                x4_o        <= x4_i ^ key_q[63:0];
                round_cnt_o <= ROUNDS;
            end else begin
                x3_o        <= x3_i;
                x4_o        <= x4_i;
                round_cnt_o <= round_cnt_o - STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_sbox_o      <= 1'b0;
            sbox_ack_o      <= 1'b0;
            sbox_addr_o     <= '0;
            sbox_new_data_o <= '0;
        end else begin
            upd_sbox_o <= wr_acc;
            sbox_ack_o <= wr_acc;
            if (wr_acc) begin
                sbox_addr_o     <= sbox_addr_i;
                sbox_new_data_o <= sbox_data_i;
            end
        end
    end

endmodule

// File: tb/tb_ascon_init_ctrl.sv
`timescale 1ns/1ps
// Bench for ascon_init_ctrl: two instances (UROL=1 and UROL=3) each driven by a
// behavioural Ascon-p model; results are checked against a reference init.
module tb_ascon_init_ctrl;

    localparam logic [63:0] IV = 64'h80400c0600000000;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   start, ready;
    logic [127:0] key_i, nonce_i;
    logic         sbox_wr;
    logic [4:0]   sbox_addr;
    logic [20:0]  sbox_data;

    wire  [1:0]        srdy, ack, upd, valid;
    wire  [1:0][4:0]   saddr;
    wire  [1:0][20:0]  sdata;
    wire  [1:0][3:0]   rc;
    wire  [1:0][319:0] st;
    wire  [1:0][319:0] pin;

    int n_cmp = 0;
    int n_err = 0;

    logic [319:0] q0[$];
    logic [319:0] q1[$];
    logic [1:0][319:0] last_exp;

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input int i);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'd0, 4'(15 - i), 4'(i)};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Permutation stub: applies u rounds starting at the round the counter points to.
    function automatic logic [319:0] perm_step(input logic [319:0] s, input logic [3:0] cnt,
                                               input int u);
        logic [319:0] r = s;
        for (int k = 0; k < u; k++) r = ascon_round(r, 12 - int'(cnt) + k);
        return r;
    endfunction

    function automatic logic [319:0] ref_init(input logic [127:0] k, input logic [127:0] n);
        logic [319:0] s = {IV, k, n};
        for (int i = 0; i < 12; i++) s = ascon_round(s, i);
        s[127:0] = s[127:0] ^ k;
        return s;
    endfunction

    assign pin[0] = perm_step(st[0], rc[0], 1);
    assign pin[1] = perm_step(st[1], rc[1], 3);

    ascon_init_ctrl #(.UROL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start[0]), .start_ready_o(srdy[0]),
        .key_i(key_i), .nonce_i(nonce_i),
        .sbox_wr_i(sbox_wr), .sbox_addr_i(sbox_addr), .sbox_data_i(sbox_data),
        .sbox_ack_o(ack[0]), .upd_sbox_o(upd[0]), .sbox_addr_o(saddr[0]),
        .sbox_new_data_o(sdata[0]), .round_cnt_o(rc[0]),
        .x0_o(st[0][319:256]), .x1_o(st[0][255:192]), .x2_o(st[0][191:128]),
        .x3_o(st[0][127:64]), .x4_o(st[0][63:0]),
        .x0_i(pin[0][319:256]), .x1_i(pin[0][255:192]), .x2_i(pin[0][191:128]),
        .x3_i(pin[0][127:64]), .x4_i(pin[0][63:0]),
        .valid_o(valid[0]), .ready_i(ready[0])
    );

    ascon_init_ctrl #(.UROL(3)) u_dut3 (
        .clk(clk), .rst(rst), .start_i(start[1]), .start_ready_o(srdy[1]),
        .key_i(key_i), .nonce_i(nonce_i),
        .sbox_wr_i(sbox_wr), .sbox_addr_i(sbox_addr), .sbox_data_i(sbox_data),
        .sbox_ack_o(ack[1]), .upd_sbox_o(upd[1]), .sbox_addr_o(saddr[1]),
        .sbox_new_data_o(sdata[1]), .round_cnt_o(rc[1]),
        .x0_o(st[1][319:256]), .x1_o(st[1][255:192]), .x2_o(st[1][191:128]),
        .x3_o(st[1][127:64]), .x4_o(st[1][63:0]),
        .x0_i(pin[1][319:256]), .x1_i(pin[1][255:192]), .x2_i(pin[1][191:128]),
        .x3_i(pin[1][127:64]), .x4_i(pin[1][63:0]),
        .valid_o(valid[1]), .ready_i(ready[1])
    );

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [319:0] q_front(input int u);
        if (u == 0) return (q0.size() > 0) ? q0[0] : '0;
        return (q1.size() > 0) ? q1[0] : '0;
    endfunction

    // Scoreboard pop: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid[0] && ready[0]) begin
                if (q0.size() == 0) chk("sb0_unexpected", 320'(valid[0]), 320'(0));
                else begin
                    last_exp[0] = q0.pop_front();
                    chk("sb0_result", st[0], last_exp[0]);
                end
            end
            if (valid[1] && ready[1]) begin
                if (q1.size() == 0) chk("sb1_unexpected", 320'(valid[1]), 320'(0));
                else begin
                    last_exp[1] = q1.pop_front();
                    chk("sb1_result", st[1], last_exp[1]);
                end
            end
        end
    end

    task automatic chk_reset(input int u);
        chk("rst_state", st[u], 320'(0));
        chk("rst_rc",    320'(rc[u]), 320'(4'hC));
        chk("rst_valid", 320'(valid[u]), 320'(0));
        chk("rst_ack",   320'(ack[u]), 320'(0));
        chk("rst_upd",   320'(upd[u]), 320'(0));
        chk("rst_addr",  320'(saddr[u]), 320'(0));
        chk("rst_data",  320'(sdata[u]), 320'(0));
        chk("rst_srdy",  320'(srdy[u]), 320'(1));
    endtask

    task automatic do_start(input int u, input logic [127:0] k, input logic [127:0] n);
        @(posedge clk); #1;
        start[u] = 1'b1; key_i = k; nonce_i = n;
        @(negedge clk);
        chk("start_srdy", 320'(srdy[u]), 320'(1));
        if (u == 0) q0.push_back(ref_init(k, n));
        else        q1.push_back(ref_init(k, n));
        @(posedge clk); #1;
        start[u] = 1'b0; key_i = ~k; nonce_i = ~n;
    endtask

    // Walks the round counter after the accept edge; optionally injects a LUT write mid-run.
    task automatic check_perm(input int u, input int urol, input bit inj);
        for (int k = 0; k < 12 / urol; k++) begin
            @(negedge clk);
            chk("perm_rc",    320'(rc[u]), 320'(12 - k * urol));
            chk("perm_valid", 320'(valid[u]), 320'(0));
            chk("perm_srdy",  320'(srdy[u]), 320'(0));
            if (inj && k == 1) begin
                sbox_wr = 1'b1; sbox_addr = 5'h0A; sbox_data = 21'h012345;
            end
            if (inj && k == 2) begin
                chk("perm_wr_upd",   320'(upd[u]), 320'(0));
                chk("perm_wr_ack",   320'(ack[u]), 320'(0));
                chk("perm_wr_addr",  320'(saddr[u]), 320'(5'h07));
                chk("idle_wr_ack",   320'(ack[1 - u]), 320'(1));
                chk("idle_wr_addr",  320'(saddr[1 - u]), 320'(5'h0A));
                sbox_wr = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_valid_lat", 320'(valid[u]), 320'(1));
        chk("done_rc",        320'(rc[u]), 320'(4'hC));
    endtask

    task automatic finish_run(input int u, input int hold);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 320'(valid[u]), 320'(1));
            chk("hold_state", st[u], q_front(u));
        end
        @(posedge clk); #1; ready[u] = 1'b1;
        @(posedge clk); #1; ready[u] = 1'b0;
        @(negedge clk);
        chk("post_valid", 320'(valid[u]), 320'(0));
        chk("post_srdy",  320'(srdy[u]), 320'(1));
        chk("post_state", st[u], last_exp[u]);
    endtask

    task automatic sbox_write(input logic [4:0] a, input logic [20:0] d);
        @(posedge clk); #1;
        sbox_wr = 1'b1; sbox_addr = a; sbox_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k1, k2, n2;
        k1 = 128'h000102030405060708090a0b0c0d0e0f;
        k2 = {$urandom, $urandom, $urandom, $urandom};
        n2 = {$urandom, $urandom, $urandom, $urandom};
        rst = 1'b1; start = '0; ready = '0; key_i = '0; nonce_i = '0;
        sbox_wr = 1'b0; sbox_addr = '0; sbox_data = '0; last_exp = '0;
        #3;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk); rst = 1'b0;

        // UROL=1 golden run with a 5-cycle stall in DONE
        do_start(0, k1, k1);
        check_perm(0, 1, 1'b0);
        finish_run(0, 5);

        // UROL=3 with the same stimulus
        do_start(1, k1, k1);
        check_perm(1, 3, 1'b0);
        finish_run(1, 0);

        // Single and back-to-back LUT writes while idle
        sbox_write(5'h07, 21'h1ABCDE);
        @(negedge clk);
        chk("wr_srdy_block", 320'(srdy[0]), 320'(0));
        chk("wr_upd_early",  320'(upd[0]), 320'(0));
        @(posedge clk); #1; sbox_wr = 1'b0;
        @(negedge clk);
        chk("wr_upd",  320'(upd[0]), 320'(1));
        chk("wr_ack",  320'(ack[0]), 320'(1));
        chk("wr_addr", 320'(saddr[0]), 320'(5'h07));
        chk("wr_data", 320'(sdata[0]), 320'(21'h1ABCDE));
        @(negedge clk);
        chk("wr_ack_pulse", 320'(ack[0]), 320'(0));
        chk("wr_upd_pulse", 320'(upd[0]), 320'(0));
        sbox_write(5'h03, 21'h000111);
        sbox_write(5'h07, 21'h1ABCDE);
        @(negedge clk);
        chk("b2b_ack0",  320'(ack[0]), 320'(1));
        chk("b2b_data0", 320'(sdata[0]), 320'(21'h000111));
        @(posedge clk); #1; sbox_wr = 1'b0;
        @(negedge clk);
        chk("b2b_ack1",  320'(ack[0]), 320'(1));
        chk("b2b_data1", 320'(sdata[0]), 320'(21'h1ABCDE));

        // LUT write during PERM is dropped; the idle UROL=3 instance takes it
        do_start(0, k2, n2);
        check_perm(0, 1, 1'b1);
        finish_run(0, 1);

        // Simultaneous start and write: write wins, start follows
        @(posedge clk); #1;
        start[0] = 1'b1; key_i = n2; nonce_i = k2;
        sbox_wr = 1'b1; sbox_addr = 5'h07; sbox_data = 21'h0F0F0;
        @(negedge clk);
        chk("both_srdy", 320'(srdy[0]), 320'(0));
        @(posedge clk); #1; sbox_wr = 1'b0;
        @(negedge clk);
        chk("both_ack",  320'(ack[0]), 320'(1));
        chk("both_data", 320'(sdata[0]), 320'(21'h0F0F0));
        chk("both_srdy_after", 320'(srdy[0]), 320'(1));
        q0.push_back(ref_init(n2, k2));
        @(posedge clk); #1; start[0] = 1'b0; key_i = '0; nonce_i = '0;
        check_perm(0, 1, 1'b0);
        finish_run(0, 0);

        // Reset in the 5th PERM cycle aborts the run
        do_start(0, k2, k1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset(0);
        chk_reset(1);
        q0.delete();
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("abort_no_valid", 320'(valid[0]), 320'(0));
        end
        do_start(0, k2, k1);
        check_perm(0, 1, 1'b0);
        finish_run(0, 1);

        repeat (2) @(negedge clk);
        chk("sb_leftover", 320'(q0.size() + q1.size()), 320'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
